dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_dmem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// Each request waits WAIT_CYCLES edges, then the response is held until the initiator consumes it.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_W   = 17'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         write_q, write_d;
    logic [15:0]  addr_q, addr_d;
    logic [15:0]  wdata_q, wdata_d;
    logic [15:0]  rdata_q, rdata_d;
    logic         err_q, err_d;
    logic         valid_q, valid_d;
    logic [15:0]  mem_q [DEPTH];
    logic [15:0]  mem_d [DEPTH];

    logic         commit_s;
    logic         c_write_s;
    logic [15:0]  c_addr_s;
    logic [15:0]  c_wdata_s;
    logic         in_range_s;
    logic [AW-1:0] idx_s;

    // Next-state, request latching and the commit of the access on entry to RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_d     = mem_q;
        commit_s  = 1'b0;
        c_write_s = write_q;
        c_addr_s  = addr_q;
        c_wdata_s = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d   = req_write;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    // With zero wait states the access commits on the acceptance edge itself.
                    c_write_s = req_write;
                    c_addr_s  = req_addr;
                    c_wdata_s = req_wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d  = ST_RESP;
                        commit_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = ST_RESP;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_range_s = ({1'b0, c_addr_s} < DEPTH_W);
        idx_s      = c_addr_s[AW-1:0];

        if (commit_s) begin
            err_d = ~in_range_s;
            if (in_range_s && !c_write_s) begin
                rdata_d = mem_q[idx_s];
            end else begin
                rdata_d = 16'd0;
            end
            if (in_range_s && c_write_s) begin
                mem_d[idx_s] = c_wdata_s;
            end else begin
                mem_d[idx_s] = mem_q[idx_s];
            end
        end else begin
            err_d = err_q;
        end

        valid_d = (state_d == ST_RESP);
    end

    // State, latched request, response registers and memory array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            rdata_q <= 16'd0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Ready is the IDLE decode, held low while reset is asserted.
    assign req_ready  = (state_q == ST_IDLE) && reset;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
// Expected responses come from a bench memory model through a scoreboard queue.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [15:0] req_addr, req_wdata, resp_rdata;
    logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_err;
    logic [15:0] b_req_addr, b_req_wdata, b_resp_rdata;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_mem [64];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model_mem[i] = 16'd0;
        sb.delete();
    endtask

    // Present a request, wait for acceptance, record the expected response.
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
        int   n = 0;
        exp_t e;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        while (!req_ready && n < 50) begin tick(); n++; end
        chk("accept_timeout", 32'(n < 50), 32'd1);
        tick();
        if (a < 16'd64) begin
            e.err = 1'b0;
            if (w) begin
                model_mem[a] = d;
                e.rdata = 16'd0;
            end else begin
                e.rdata = model_mem[a];
            end
        end else begin
            e.err = 1'b1;
            e.rdata = 16'd0;
        end
        sb.push_back(e);
        req_valid = 1'b0;
    endtask

    // Count edges from acceptance to resp_valid, optionally scrambling request inputs meanwhile.
    task automatic await_resp(input int exp_lat, input bit scramble);
        int   n = 1;
        exp_t e;
        while (!resp_valid && n < 40) begin
            if (scramble) begin
                req_valid = 1'b1;
                req_write = 1'($urandom_range(0, 1));
                req_addr  = 16'($urandom_range(8, 63));
                req_wdata = 16'($urandom);
            end
            tick();
            n++;
        end
        req_valid = 1'b0;
        chk("latency", 32'(n), 32'(exp_lat));
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
            chk("resp_err", 32'(resp_err), 32'(e.err));
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        tick();
        chk("resp_valid_drop", 32'(resp_valid), 32'd0);
        chk("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d);
        issue(w, a, d);
        await_resp(3, 1'b0);
        finish_resp();
    endtask

    initial begin
        int prev;
        int last_acc;
        int acc;
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 16'd0; req_wdata = 16'd0; resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 16'd0; b_req_wdata = 16'd0; b_resp_ready = 1'b1;
        model_clear();
        tick(); tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        reset = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_ready_b", 32'(b_req_ready), 32'd1);

        // Basic store/load, memory starts cleared.
        txn(1'b0, 16'd0, 16'd0);
        txn(1'b1, 16'd63, 16'hA5A5);
        txn(1'b1, 16'd0, 16'h0F0F);
        txn(1'b1, 16'd5, 16'hBEEF);
        txn(1'b0, 16'd5, 16'd0);

        // Out-of-range accesses leave memory alone.
        txn(1'b0, 16'd64, 16'd0);
        txn(1'b1, 16'd64, 16'hDEAD);
        txn(1'b1, 16'hFFFF, 16'hDEAD);
        txn(1'b0, 16'd63, 16'd0);
        txn(1'b0, 16'd0, 16'd0);

        // Backpressure: response held for 10 cycles while a new request is offered.
        resp_ready = 1'b0;
        issue(1'b0, 16'd5, 16'd0);
        await_resp(3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 16'd5; req_wdata = 16'h0000;
            tick();
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_resp_rdata", 32'(resp_rdata), 32'h0000BEEF);
            chk("bp_resp_err", 32'(resp_err), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        finish_resp();
        txn(1'b0, 16'd5, 16'd0);

        // Request inputs churn during WAIT; the latched values must be used.
        issue(1'b1, 16'd7, 16'h1111);
        await_resp(3, 1'b1);
        finish_resp();
        txn(1'b0, 16'd7, 16'd0);

        // Reset during WAIT aborts the store and clears memory.
        issue(1'b1, 16'd3, 16'h1234);
        tick();
        reset = 1'b0;
        #1;
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        chk("abort_rdata", 32'(resp_rdata), 32'd0);
        chk("abort_err", 32'(resp_err), 32'd0);
        model_clear();
        tick();
        reset = 1'b1;
        #1;
        txn(1'b0, 16'd3, 16'd0);
        txn(1'b0, 16'd5, 16'd0);

        // Zero-wait instance: back-to-back stores with req_valid held high.
        last_acc = -1;
        acc = 0;
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 16'd1;
        for (int i = 0; i < 8; i++) begin
            prev = int'(b_req_ready);
            b_req_wdata = 16'(i);
            tick();
            if (prev != 0) begin
                chk("b_resp_valid", 32'(b_resp_valid), 32'd1);
                chk("b_resp_err", 32'(b_resp_err), 32'd0);
                chk("b_resp_rdata", 32'(b_resp_rdata), 32'd0);
                if (last_acc >= 0) chk("b_accept_gap", 32'(i - last_acc), 32'd2);
                last_acc = i;
                acc++;
            end
        end
        chk("b_accept_count", 32'(acc), 32'd4);
        b_req_valid = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
